// File: rtl/wb_daq_pkg.sv
// Shared DAQ channel constants and a small index-width helper.
package wb_daq_pkg;
  localparam int DAQ_DW         = 32;
  localparam int DAQ_ADC_DW     = 8;
  localparam int DAQ_LANES      = DAQ_DW / DAQ_ADC_DW;
  localparam int DAQ_FIFO_DEPTH = 4;

  // Width of an index over n items; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DAQ_LANE_W = idx_w(DAQ_LANES);
endpackage

// File: rtl/wb_daq_sync_fifo.sv
// Single-clock FIFO; head shown combinationally (0 when empty), count-based full/empty.
// Push while full is accepted only if a pop happens in the same cycle, otherwise dropped.
module wb_daq_sync_fifo
  import wb_daq_pkg::*;
#(
  parameter int width = DAQ_DW,
  parameter int depth = DAQ_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [width-1:0]        din,
  output logic [width-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(depth):0]  count
);
  localparam int aw = idx_w(depth);
  localparam int cw = $clog2(depth) + 1;

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == cw'(depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_daq_sample_packer.sv
// Packs ADC samples little-endian into dw-bit words queued for the bus master; word visible 1 cycle after completion.
// Full FIFO with no pop drops the word and sets sticky overflow. Optional flush port: WB_DAQ_PACKER_FLUSH_EN.
module wb_daq_sample_packer
  import wb_daq_pkg::*;
#(
  parameter int dw         = DAQ_DW,
  parameter int adc_dw     = DAQ_ADC_DW,
  parameter int fifo_depth = DAQ_FIFO_DEPTH
) (
  input  logic                         wb_clk,
  input  logic                         wb_rst,
  input  logic                         enable,
  input  logic                         sample_valid,
  input  logic [adc_dw-1:0]            sample_data,
  input  logic                         data_ack,
  input  logic                         clear_overflow,
`ifdef WB_DAQ_PACKER_FLUSH_EN
  input  logic                         flush,
`endif
  output logic [dw-1:0]                data_out,
  output logic                         start_sram,
  output logic [$clog2(fifo_depth):0]  fill_level,
  output logic                         overflow
);
  localparam int n  = dw / adc_dw;
  localparam int lw = idx_w(n);

  logic [lw-1:0] lane;
  logic [lw-1:0] lane_nxt;
  logic [dw-1:0] partial;
  logic [dw-1:0] partial_nxt;
  logic [dw-1:0] push_word;
  logic          push_req;
  logic          flush_req;
  logic          full;
  logic          empty;
  logic          drop;
  int            filled;

`ifdef WB_DAQ_PACKER_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  always_comb begin
    lane_nxt    = lane;
    partial_nxt = partial;
    push_word   = partial;
    push_req    = 1'b0;
    filled      = 0;
    if (!enable) begin
      lane_nxt    = '0;
      partial_nxt = '0;
    end else begin
      if (sample_valid) partial_nxt[int'(lane)*adc_dw +: adc_dw] = sample_data;
      filled = int'(lane) + (sample_valid ? 1 : 0);
      if (sample_valid && lane == lw'(n-1)) begin
        push_req  = 1'b1;
        push_word = partial_nxt;
        lane_nxt  = '0;
      end else if (flush_req && filled != 0) begin
        // Flushed word carries only the lanes written so far.
        push_req = 1'b1;
        lane_nxt = '0;
        for (int i = 0; i < n; i++)
          push_word[i*adc_dw +: adc_dw] = (i < filled) ? partial_nxt[i*adc_dw +: adc_dw] : '0;
      end else if (sample_valid) begin
        lane_nxt = lane + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      lane    <= '0;
      partial <= '0;
    end else begin
      lane    <= lane_nxt;
      partial <= partial_nxt;
    end
  end

  // A full FIFO is never empty, so data_ack alone tells whether a slot frees up.
  assign drop = push_req && full && !data_ack;

  always_ff @(posedge wb_clk) begin
    if (wb_rst)              overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

  wb_daq_sync_fifo #(
    .width (dw),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .push  (push_req),
    .pop   (data_ack),
    .din   (push_word),
    .dout  (data_out),
    .full  (full),
    .empty (empty),
    .count (fill_level)
  );

  assign start_sram = !empty;
endmodule
